// File: rtl/matrix_add_sequencer.sv
// ============================================================================
// matrix_add_sequencer : R x C signed-magnitude element-wise add sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_add_sequencer #(
  parameter int R = 6,
  parameter int C = 6,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [$clog2(R)-1:0] rd_row,
  output logic [$clog2(C)-1:0] rd_col,
  input  logic [N-1:0]         a_data,
  input  logic [N-1:0]         b_data,
  output logic                 wr_en,
  output logic [$clog2(R)-1:0] wr_row,
  output logic [$clog2(C)-1:0] wr_col,
  output logic [N-1:0]         wr_data,
  output logic                 ovf
);

  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic            rd_en_q;
  logic            wr_en_q;
  logic            done_q;
  logic            pipe_v;
  logic [RW-1:0]   pipe_row;
  logic [CW-1:0]   pipe_col;

  logic            sa, sb, rs, sat;
  logic [N-2:0]    ma, mb, mag;
  logic [N-1:0]    msum;
  logic [N-1:0]    sum;

  // Strobes are held internally across a hold so the pending transfer fires once on release.
  assign rd_en = rd_en_q & ~hold;
  assign wr_en = wr_en_q & ~hold;
  assign done  = done_q  & ~hold;

  always_comb begin
    ma   = a_data[N-2:0];
    mb   = b_data[N-2:0];
    sa   = a_data[N-1] & (|ma);
    sb   = b_data[N-1] & (|mb);
    msum = {1'b0, ma} + {1'b0, mb};
    sat  = 1'b0;
    rs   = sa;
    mag  = '0;
    if (sa == sb) begin
      if (msum[N-1]) begin
        sat = 1'b1;
        mag = '1;
      end else begin
        mag = msum[N-2:0];
      end
    end else if (ma >= mb) begin
      mag = ma - mb;
      rs  = sa;
    end else begin
      mag = mb - ma;
      rs  = sb;
    end
    if (mag == '0) rs = 1'b0;
    sum = {rs, mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      pipe_v   <= 1'b0;
      pipe_row <= '0;
      pipe_col <= '0;
      wr_en_q  <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_data  <= '0;
      ovf      <= 1'b0;
    end else if (!hold) begin
      wr_en_q  <= pipe_v;
      if (pipe_v) begin
        wr_row  <= pipe_row;
        wr_col  <= pipe_col;
        wr_data <= sum;
        if (sat) ovf <= 1'b1;
      end
      pipe_v   <= rd_en_q;
      pipe_row <= rd_row;
      pipe_col <= rd_col;
      done_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_en_q <= 1'b1;
            rd_row  <= '0;
            rd_col  <= '0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          if (rd_row == ROW_LAST && rd_col == COL_LAST) begin
            state   <= DRAIN;
            rd_en_q <= 1'b0;
          end else if (rd_col == COL_LAST) begin
            rd_col <= '0;
            rd_row <= rd_row + 1'b1;
          end else begin
            rd_col <= rd_col + 1'b1;
          end
        end
        DRAIN: begin
          // Last write is on the bus once nothing is left in the operand stage.
          if (wr_en_q && !pipe_v) begin
            state  <= DONE;
            busy   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_add_sequencer.sv
// ============================================================================
// tb_matrix_add_sequencer : scoreboard bench for matrix_add_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] data;
  } wr_t;

  // ---------------- DUT 1 : 6 x 6 ----------------
  logic        start1 = 1'b0, hold1 = 1'b0;
  logic        busy1, done1, rd_en1, wr_en1, ovf1;
  logic [2:0]  rd_row1, rd_col1, wr_row1, wr_col1;
  logic [31:0] a1 = '0, b1 = '0, wr_data1;
  logic [31:0] ma1 [36];
  logic [31:0] mb1 [36];
  wr_t         q1 [$];
  wr_t         ex1;
  int e0_1 = 0, wr_cnt1 = 0, done_cnt1 = 0, first_wr1 = 0, last_wr1 = 0, done_cyc1 = 0;
  logic        busy_done1 = 1'b0;
  logic [31:0] last_data1 = '0;
  logic        exp_ovf1 = 1'b0;

  matrix_add_sequencer #(.R(6), .C(6), .N(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .busy(busy1), .done(done1), .rd_en(rd_en1),
    .rd_row(rd_row1), .rd_col(rd_col1),
    .a_data(a1), .b_data(b1),
    .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1),
    .wr_data(wr_data1), .ovf(ovf1)
  );

  always @(posedge clk) if (rd_en1) begin
    a1 <= ma1[int'(rd_row1) * 6 + int'(rd_col1)];
    b1 <= mb1[int'(rd_row1) * 6 + int'(rd_col1)];
  end

  always @(negedge clk) begin
    if (done1) begin
      done_cnt1++;
      done_cyc1  = cyc - e0_1 + 1;
      busy_done1 = busy1;
    end
    if (wr_en1) begin
      wr_cnt1++;
      if (wr_cnt1 == 1) first_wr1 = cyc - e0_1 + 1;
      last_wr1   = cyc - e0_1 + 1;
      last_data1 = wr_data1;
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL wr1_unexpected: got row=%0d col=%0d data=%h, no write expected", wr_row1, wr_col1, wr_data1);
      end else begin
        ex1 = q1.pop_front();
        if ({wr_row1, wr_col1, wr_data1} !== {ex1.row[2:0], ex1.col[2:0], ex1.data}) begin
          bad++;
          $display("FAIL wr1_data: got (%0d,%0d)=%h, expected (%0d,%0d)=%h",
                   wr_row1, wr_col1, wr_data1, ex1.row, ex1.col, ex1.data);
        end
      end
    end
  end

  // ---------------- DUT 2 : 2 x 2 ----------------
  logic        start2 = 1'b0, hold2 = 1'b0;
  logic        busy2, done2, rd_en2, wr_en2, ovf2;
  logic [0:0]  rd_row2, rd_col2, wr_row2, wr_col2;
  logic [31:0] a2 = '0, b2 = '0, wr_data2;
  logic [31:0] ma2 [4];
  logic [31:0] mb2 [4];
  wr_t         q2 [$];
  wr_t         ex2;
  int e0_2 = 0, wr_cnt2 = 0, done_cnt2 = 0, done_cyc2 = 0;

  matrix_add_sequencer #(.R(2), .C(2), .N(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .hold(hold2),
    .busy(busy2), .done(done2), .rd_en(rd_en2),
    .rd_row(rd_row2), .rd_col(rd_col2),
    .a_data(a2), .b_data(b2),
    .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2),
    .wr_data(wr_data2), .ovf(ovf2)
  );

  always @(posedge clk) if (rd_en2) begin
    a2 <= ma2[int'(rd_row2) * 2 + int'(rd_col2)];
    b2 <= mb2[int'(rd_row2) * 2 + int'(rd_col2)];
  end

  always @(negedge clk) begin
    if (done2) begin
      done_cnt2++;
      done_cyc2 = cyc - e0_2 + 1;
    end
    if (wr_en2) begin
      wr_cnt2++;
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL wr2_unexpected: got row=%0d col=%0d data=%h, no write expected", wr_row2, wr_col2, wr_data2);
      end else begin
        ex2 = q2.pop_front();
        if ({wr_row2, wr_col2, wr_data2} !== {ex2.row[0], ex2.col[0], ex2.data}) begin
          bad++;
          $display("FAIL wr2_data: got (%0d,%0d)=%h, expected (%0d,%0d)=%h",
                   wr_row2, wr_col2, wr_data2, ex2.row, ex2.col, ex2.data);
        end
      end
    end
  end

  // Reference: convert to integers, add, clamp, convert back.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, output logic sat);
    longint va, vb, s;
    longint mx;
    mx  = 64'sh7FFF_FFFF;
    va  = longint'({33'd0, a[30:0]});
    vb  = longint'({33'd0, b[30:0]});
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    s   = va + vb;
    sat = 1'b0;
    if (s > mx) begin s = mx; sat = 1'b1; end
    else if (s < -mx) begin s = -mx; sat = 1'b1; end
    if (s < 0) return {1'b1, 31'(-s)};
    return {1'b0, 31'(s)};
  endfunction

  task automatic load1(input int mode, input logic [31:0] ca, input logic [31:0] cb);
    logic s;
    exp_ovf1 = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (mode == 0) begin
        ma1[i] = ca;
        mb1[i] = cb;
      end else begin
        ma1[i] = $urandom;
        mb1[i] = $urandom;
        if (i % 9 == 0) ma1[i] = 32'h8000_0000;
        if (i % 9 == 1) mb1[i] = ma1[i] ^ 32'h8000_0000;
        if (i % 9 == 2) begin ma1[i] = ma1[i] >> 2; mb1[i] = mb1[i] >> 2; end
      end
      q1.push_back('{32'(i / 6), 32'(i % 6), ref_add(ma1[i], mb1[i], s)});
      exp_ovf1 |= s;
    end
  endtask

  task automatic go1();
    wr_cnt1 = 0; done_cnt1 = 0; first_wr1 = 0; last_wr1 = 0; done_cyc1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; e0_1 = cyc;
  endtask

  task automatic wait_done1();
    int n = 0;
    while (done_cnt1 == 0 && n < 300) begin @(posedge clk); n++; end
    #2;
    total++;
    if (done_cnt1 == 0) begin
      bad++;
      $display("FAIL done1_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy1, done1, rd_en1, wr_en1, ovf1, rd_row1, rd_col1, wr_row1, wr_col1, wr_data1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1: got busy=%b done=%b rd_en=%b wr_en=%b ovf=%b wr_data=%h, expected all 0",
               busy1, done1, rd_en1, wr_en1, ovf1, wr_data1);
    end
    total++;
    if ({busy2, done2, rd_en2, wr_en2, ovf2, rd_row2, rd_col2, wr_row2, wr_col2, wr_data2} !== '0) begin
      bad++;
      $display("FAIL reset_dut2: got busy=%b done=%b rd_en=%b wr_en=%b ovf=%b wr_data=%h, expected all 0",
               busy2, done2, rd_en2, wr_en2, ovf2, wr_data2);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    load1(0, 32'h0005_6FC2, 32'h0006_487E);
    go1();
    wait_done1();
    total++; if (first_wr1 !== 3)  begin bad++; $display("FAIL basic_first_wr: got %0d expected 3", first_wr1); end
    total++; if (last_wr1 !== 38)  begin bad++; $display("FAIL basic_last_wr: got %0d expected 38", last_wr1); end
    total++; if (done_cyc1 !== 39) begin bad++; $display("FAIL basic_done_cyc: got %0d expected 39", done_cyc1); end
    total++; if (wr_cnt1 !== 36)   begin bad++; $display("FAIL basic_wr_cnt: got %0d expected 36", wr_cnt1); end
    total++; if (last_data1 !== 32'h000B_B840) begin bad++; $display("FAIL basic_value: got %h expected 000bb840", last_data1); end
    total++; if (busy_done1 !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b expected 0", busy_done1); end
    total++; if (ovf1 !== 1'b0)    begin bad++; $display("FAIL basic_ovf: got %b expected 0", ovf1); end
    total++; if (q1.size() !== 0)  begin bad++; $display("FAIL basic_pending: got %0d left expected 0", q1.size()); end
  endtask

  task automatic test_random();
    load1(1, '0, '0);
    go1();
    wait_done1();
    total++; if (ovf1 !== exp_ovf1) begin bad++; $display("FAIL random_ovf: got %b expected %b", ovf1, exp_ovf1); end
    total++; if (q1.size() !== 0)   begin bad++; $display("FAIL random_pending: got %0d left expected 0", q1.size()); end
  endtask

  task automatic test_saturate();
    load1(0, 32'h7FFF_FFFF, 32'h0000_0001);
    go1();
    wait_done1();
    repeat (3) @(posedge clk);
    #1;
    total++; if (last_data1 !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_value: got %h expected 7fffffff", last_data1); end
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL sat_ovf_sticky: got %b expected 1", ovf1); end
  endtask

  task automatic test_signs();
    load1(0, 32'h8000_0005, 32'h0000_0003);
    go1();
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL signs_ovf_clear: got %b expected 0", ovf1); end
    wait_done1();
    total++; if (last_data1 !== 32'h8000_0002) begin bad++; $display("FAIL signs_diff: got %h expected 80000002", last_data1); end
    load1(0, 32'h8000_0004, 32'h0000_0004);
    go1();
    wait_done1();
    total++; if (last_data1 !== 32'h0000_0000) begin bad++; $display("FAIL signs_zero: got %h expected 00000000", last_data1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL signs_ovf: got %b expected 0", ovf1); end
  endtask

  task automatic test_start_while_busy();
    load1(1, '0, '0);
    go1();
    repeat (4) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1();
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_cnt1 !== 36)   begin bad++; $display("FAIL busy_start_wr_cnt: got %0d expected 36", wr_cnt1); end
    total++; if (done_cnt1 !== 1)  begin bad++; $display("FAIL busy_start_done_cnt: got %0d expected 1", done_cnt1); end
    total++; if (busy1 !== 1'b0)   begin bad++; $display("FAIL busy_start_restart: got busy=%b expected 0", busy1); end
  endtask

  task automatic test_hold();
    logic s;
    int n;
    // start while held in idle must be dropped
    @(posedge clk); #1 hold1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 hold1 = 1'b0; start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL hold_idle_start: got busy=%b expected 0", busy1); end

    for (int i = 0; i < 4; i++) begin
      ma2[i] = $urandom;
      mb2[i] = $urandom >> 1;
      q2.push_back('{32'(i / 2), 32'(i % 2), ref_add(ma2[i], mb2[i], s)});
    end
    wr_cnt2 = 0; done_cnt2 = 0; done_cyc2 = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; e0_2 = cyc;
    @(posedge clk);
    @(posedge clk); #1 hold2 = 1'b1;
    @(posedge clk); #1;
    total++; if ({rd_en2, wr_en2} !== 2'b00) begin bad++; $display("FAIL hold_strobes: got rd_en=%b wr_en=%b expected 0 0", rd_en2, wr_en2); end
    repeat (2) @(posedge clk);
    #1 hold2 = 1'b0;
    n = 0;
    while (done_cnt2 == 0 && n < 100) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    #1;
    total++; if (done_cyc2 !== 10) begin bad++; $display("FAIL hold_done_cyc: got %0d expected 10", done_cyc2); end
    total++; if (wr_cnt2 !== 4)    begin bad++; $display("FAIL hold_wr_cnt: got %0d expected 4", wr_cnt2); end
    total++; if (done_cnt2 !== 1)  begin bad++; $display("FAIL hold_done_cnt: got %0d expected 1", done_cnt2); end
  endtask

  task automatic test_reset_mid();
    int w;
    load1(1, '0, '0);
    go1();
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy1, done1, rd_en1, wr_en1, ovf1, rd_row1, rd_col1, wr_row1, wr_col1, wr_data1} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got busy=%b rd_en=%b wr_en=%b ovf=%b row=%0d col=%0d wr_data=%h, expected all 0",
               busy1, rd_en1, wr_en1, ovf1, rd_row1, rd_col1, wr_data1);
    end
    q1.delete();
    @(posedge clk); #1 rst = 1'b0;
    w = wr_cnt1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (wr_cnt1 !== w) begin bad++; $display("FAIL midrst_stray_write: got %0d writes expected %0d", wr_cnt1, w); end
    load1(1, '0, '0);
    go1();
    wait_done1();
    total++; if (first_wr1 !== 3)   begin bad++; $display("FAIL midrst_first_wr: got %0d expected 3", first_wr1); end
    total++; if (q1.size() !== 0)   begin bad++; $display("FAIL midrst_pending: got %0d left expected 0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_saturate();
    test_signs();
    test_start_while_busy();
    test_hold();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
